// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port among NUM_REQ producers,
// granting bounded bursts and back-pressuring everyone on fifo_full.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   owner, owner_nx;
  logic [IDX_W-1:0]   last_owner, last_owner_nx;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_nx;
  logic [NUM_REQ-1:0] gnt_nx;
  logic               busy_nx;

  logic [IDX_W-1:0]   pick_base, pick;
  logic               pick_vld;
  logic               owner_req, accept, last_word;

  assign owner_req = req[owner];
  assign accept    = busy & owner_req & ~fifo_full;
  assign last_word = (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign pick_base = (state == BURST) ? owner : last_owner;

  // Round-robin search starting just after pick_base; pick_base itself is tried last
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!pick_vld && req[IDX_W'((int'(pick_base) + k) % int'(NUM_REQ))]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'((int'(pick_base) + k) % int'(NUM_REQ));
      end
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    burst_cnt_nx  = burst_cnt;
    gnt_nx        = gnt;
    busy_nx       = busy;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx     = BURST;
          owner_nx     = pick;
          gnt_nx       = NUM_REQ'(1) << pick;
          busy_nx      = 1'b1;
          burst_cnt_nx = '0;
        end
      end
      BURST: begin
        if ((accept && last_word) || !owner_req) begin
          // Release: re-arbitrate in the same edge so there is no idle bubble
          last_owner_nx = owner;
          burst_cnt_nx  = '0;
          if (pick_vld) begin
            owner_nx = pick;
            gnt_nx   = NUM_REQ'(1) << pick;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            busy_nx  = 1'b0;
          end
        end else if (accept) begin
          burst_cnt_nx = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      burst_cnt  <= burst_cnt_nx;
      gnt        <= gnt_nx;
      busy       <= busy_nx;
    end
  end

  assign fifo_wr = accept;
  assign ack     = accept ? gnt : '0;

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (busy && owner == IDX_W'(i)) fifo_data = req_data[i*DATA_W +: DATA_W];
    end
  end

endmodule
